// File: rtl/tx_uart_if.sv
// Write-side bus of the UART transmitter: byte strobe and data in,
// holding-register status out.
interface tx_uart_if #(
  parameter int NB_DATA = 8
);
  logic               i_tx_start;
  logic [NB_DATA-1:0] i_data;
  logic               o_ready;
  logic               o_busy;

  // The producer of bytes.
  modport master (
    output i_tx_start, i_data,
    input  o_ready, o_busy
  );

  // The transmitter itself.
  modport slave (
    input  i_tx_start, i_data,
    output o_ready, o_busy
  );
endinterface

// File: rtl/tx_uart.sv
// UART transmitter: start bit, NB_DATA data bits LSB first, N_STOP_BITS stop
// bits, timed by the shared 16x oversample tick. A one-deep holding register
// lets the next byte be written mid-frame so frames run back-to-back.
module tx_uart #(
  parameter int NB_DATA         = 8,
  parameter int N_TICKS_PER_BIT = 16,
  parameter int N_STOP_BITS     = 2,
  parameter int NB_COUNT        = 6,
  parameter int NB_DATA_COUNT   = 4
) (
  input  logic      i_clock,
  input  logic      i_reset,
  input  logic      i_s_tick,
  tx_uart_if.slave  bus,
  output logic      o_tx,
  output logic      o_tx_done_tick
);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  localparam logic [NB_COUNT-1:0]      BIT_LAST  = NB_COUNT'(N_TICKS_PER_BIT - 1);
  localparam logic [NB_COUNT-1:0]      STOP_LAST = NB_COUNT'(N_STOP_BITS * N_TICKS_PER_BIT - 1);
  localparam logic [NB_DATA_COUNT-1:0] DATA_LAST = NB_DATA_COUNT'(NB_DATA - 1);

  state_t                   r_state;
  logic [NB_COUNT-1:0]      r_tick_cnt;
  logic [NB_DATA_COUNT-1:0] r_data_cnt;
  logic [NB_DATA-1:0]       r_shift;
  logic [NB_DATA-1:0]       r_hold;
  logic                     r_hold_valid;
  logic                     r_tx;
  logic                     r_done_tick;

  logic w_accept;
  logic w_stop_end;
  logic w_load;

  // A strobe is taken only into an empty holding register; a frame is loaded
  // from a full one either from IDLE or on the tick that ends the last stop bit.
  assign w_accept   = bus.i_tx_start && !r_hold_valid;
  assign w_stop_end = (r_state == STOP) && i_s_tick && (r_tick_cnt == STOP_LAST);
  assign w_load     = r_hold_valid && ((r_state == IDLE) || w_stop_end);

  // Frame sequencer, holding register and registered line outputs.
  // NOTE: all state uses non-blocking assignments so every register samples
  // pre-edge values; the later w_load block deliberately overrides the case.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state      <= IDLE;
      r_tick_cnt   <= '0;
      r_data_cnt   <= '0;
      r_shift      <= '0;
      r_hold       <= '0;
      r_hold_valid <= 1'b0;
      r_tx         <= 1'b1;
      r_done_tick  <= 1'b0;
    end else begin
      r_done_tick <= 1'b0;

      if (w_accept) begin
        r_hold       <= bus.i_data;
        r_hold_valid <= 1'b1;
      end

      case (r_state)
        IDLE: begin
          r_tx <= 1'b1;
        end
        START: begin
          if (i_s_tick) begin
            if (r_tick_cnt == BIT_LAST) begin
              r_tick_cnt <= '0;
              r_data_cnt <= '0;
              r_tx       <= r_shift[0];
              r_state    <= DATA;
            end else begin
              r_tick_cnt <= r_tick_cnt + 1'b1;
            end
          end
        end
        DATA: begin
          if (i_s_tick) begin
            if (r_tick_cnt == BIT_LAST) begin
              r_tick_cnt <= '0;
              r_shift    <= r_shift >> 1;
              if (r_data_cnt == DATA_LAST) begin
                r_state <= STOP;
                r_tx    <= 1'b1;
              end else begin
                r_data_cnt <= r_data_cnt + 1'b1;
                r_tx       <= r_shift[1];
              end
            end else begin
              r_tick_cnt <= r_tick_cnt + 1'b1;
            end
          end
        end
        STOP: begin
          if (i_s_tick) begin
            if (r_tick_cnt == STOP_LAST) begin
              r_done_tick <= 1'b1;
              r_tick_cnt  <= '0;
              r_state     <= IDLE;
              r_tx        <= 1'b1;
            end else begin
              r_tick_cnt <= r_tick_cnt + 1'b1;
            end
          end
        end
        default: begin
          r_state <= IDLE;
          r_tx    <= 1'b1;
        end
      endcase

      // Start a new frame from the pending byte; wins over the IDLE/STOP
      // assignments above so a back-to-back frame has no high gap.
      if (w_load) begin
        r_state      <= START;
        r_shift      <= r_hold;
        r_hold_valid <= 1'b0;
        r_tick_cnt   <= '0;
        r_tx         <= 1'b0;
      end
    end
  end

  assign o_tx           = r_tx;
  assign o_tx_done_tick = r_done_tick;
  assign bus.o_ready    = ~r_hold_valid;
  assign bus.o_busy     = (r_state != IDLE) | r_hold_valid;

endmodule

// File: tb/tb_tx_uart.sv
// Directed and random bench for tx_uart. A line monitor decodes every frame at
// mid-bit from the tick count and compares it with a scoreboard of accepted bytes.
module tb_tx_uart;

  localparam int TICKS_PER_BIT = 16;
  localparam int FRAME_TICKS   = 176;

  logic i_clock = 1'b0;
  logic i_reset = 1'b1;
  logic i_s_tick = 1'b0;
  logic o_tx;
  logic o_tx_done_tick;

  tx_uart_if #(.NB_DATA(8)) bus ();

  tx_uart dut (
    .i_clock        (i_clock),
    .i_reset        (i_reset),
    .i_s_tick       (i_s_tick),
    .bus            (bus),
    .o_tx           (o_tx),
    .o_tx_done_tick (o_tx_done_tick)
  );

  always #5 i_clock = ~i_clock;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Oversample tick: one clock wide, every tick_div clocks, changed on the falling edge.
  int tick_div = 2;
  int tick_phase = 0;
  always @(negedge i_clock) begin
    tick_phase = tick_phase + 1;
    i_s_tick = ((tick_phase % tick_div) == 0);
  end

  logic [7:0] sb[$];

  // Line monitor, sampling 1 time unit after each rising edge.
  bit          mon_active = 1'b0;
  int          mon_ticks = 0;
  logic [10:0] mon_bits = '0;
  logic [10:0] mon_last_bits = '0;
  int          mon_frames = 0;
  int          done_count = 0;
  int          b2b_count = 0;

  always @(posedge i_clock) begin
    #1;
    if (o_tx_done_tick === 1'b1) done_count++;
    if (i_reset) begin
      mon_active = 1'b0;
    end else begin
      if (mon_active && i_s_tick) begin
        mon_ticks++;
        if (mon_ticks >= 8 && ((mon_ticks - 8) % TICKS_PER_BIT) == 0 &&
            ((mon_ticks - 8) / TICKS_PER_BIT) <= 10)
          mon_bits[(mon_ticks - 8) / TICKS_PER_BIT] = o_tx;
        if (mon_ticks == FRAME_TICKS) begin
          check("done_at_176", {31'b0, o_tx_done_tick}, 32'd1);
          check("start_bit", {31'b0, mon_bits[0]}, 32'd0);
          check("stop_bits", {30'b0, mon_bits[10:9]}, 32'h3);
          if (sb.size() == 0) begin
            check("sb_nonempty", 32'd0, 32'd1);
          end else begin
            logic [7:0] exp_byte;
            exp_byte = sb.pop_front();
            check("frame_data", {24'b0, mon_bits[8:1]}, {24'b0, exp_byte});
          end
          mon_last_bits = mon_bits;
          mon_frames++;
          mon_active = 1'b0;
          if (o_tx === 1'b0) b2b_count++;
        end
      end
      if (!mon_active && o_tx === 1'b0) begin
        mon_active = 1'b1;
        mon_ticks = 0;
        mon_bits = '0;
      end
    end
  end

  task automatic send(input logic [7:0] d, output bit accepted);
    @(negedge i_clock);
    bus.i_tx_start = 1'b1;
    bus.i_data = d;
    accepted = bus.o_ready;
    if (accepted) sb.push_back(d);
    @(negedge i_clock);
    bus.i_tx_start = 1'b0;
    bus.i_data = 8'($urandom);
  endtask

  task automatic wait_frames(input int target, input int budget, input string tag);
    for (int i = 0; i < budget && mon_frames < target; i++) @(negedge i_clock);
    check(tag, mon_frames, target);
  endtask

  task automatic wait_in_frame(input int min_ticks, input int budget, input string tag);
    bit reached = 1'b0;
    for (int i = 0; i < budget && !reached; i++) begin
      @(negedge i_clock);
      reached = mon_active && (mon_ticks >= min_ticks);
    end
    check(tag, {31'b0, reached}, 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    bit acc;
    bit stay_high;
    int f0, d0, b0, n_acc, attempts;

    bus.i_tx_start = 1'b0;
    bus.i_data = 8'h00;

    // 1: reset values, then idle ticks leave the line high.
    repeat (3) @(posedge i_clock);
    @(negedge i_clock);
    check("rst_tx", {31'b0, o_tx}, 32'd1);
    check("rst_ready", {31'b0, bus.o_ready}, 32'd1);
    check("rst_busy", {31'b0, bus.o_busy}, 32'd0);
    check("rst_done", {31'b0, o_tx_done_tick}, 32'd0);
    i_reset = 1'b0;
    stay_high = 1'b1;
    repeat (100 * 2) begin
      @(negedge i_clock);
      if (o_tx !== 1'b1) stay_high = 1'b0;
    end
    check("idle_high", {31'b0, stay_high}, 32'd1);
    check("idle_frames", mon_frames, 32'd0);

    // 2: single byte, latency and bit-exact frame.
    d0 = done_count;
    send(8'hA5, acc);
    check("a5_accept", {31'b0, acc}, 32'd1);
    check("a5_ready_low", {31'b0, bus.o_ready}, 32'd0);
    check("a5_tx_not_yet", {31'b0, o_tx}, 32'd1);
    @(negedge i_clock);
    check("a5_tx_start", {31'b0, o_tx}, 32'd0);
    check("a5_ready_back", {31'b0, bus.o_ready}, 32'd1);
    check("a5_busy", {31'b0, bus.o_busy}, 32'd1);
    wait_frames(1, 1000, "a5_frame_end");
    check("a5_bits", {21'b0, mon_last_bits}, 32'h74A);
    @(negedge i_clock);
    check("a5_done_count", done_count - d0, 32'd1);
    check("a5_idle_busy", {31'b0, bus.o_busy}, 32'd0);

    // 3: byte written during DATA runs back-to-back with no high gap.
    f0 = mon_frames; d0 = done_count; b0 = b2b_count;
    send(8'h00, acc);
    wait_in_frame(24, 1000, "b2b_in_data");
    check("b2b_ready_data", {31'b0, bus.o_ready}, 32'd1);
    send(8'hFF, acc);
    check("b2b_accept", {31'b0, acc}, 32'd1);
    check("b2b_ready_low", {31'b0, bus.o_ready}, 32'd0);
    wait_frames(f0 + 2, 2000, "b2b_frames");
    @(negedge i_clock);
    check("b2b_no_gap", b2b_count - b0, 32'd1);
    check("b2b_done_count", done_count - d0, 32'd2);

    // 4: strobe while the holding register is full is ignored.
    f0 = mon_frames;
    send(8'h11, acc);
    send(8'h22, acc);
    check("ign_second_accept", {31'b0, acc}, 32'd1);
    send(8'h5A, acc);
    check("ign_rejected", {31'b0, acc}, 32'd0);
    wait_frames(f0 + 2, 2000, "ign_frames");
    repeat (400) @(negedge i_clock);
    check("ign_no_extra", mon_frames, f0 + 2);
    check("ign_sb_empty", sb.size(), 32'd0);

    // 5: reset during data bit 3 aborts the frame without a done pulse.
    f0 = mon_frames; d0 = done_count;
    send(8'h3C, acc);
    wait_in_frame(8 + 16 * 4, 1000, "rst_in_bit3");
    i_reset = 1'b1;
    @(negedge i_clock);
    check("midrst_tx", {31'b0, o_tx}, 32'd1);
    check("midrst_ready", {31'b0, bus.o_ready}, 32'd1);
    check("midrst_busy", {31'b0, bus.o_busy}, 32'd0);
    i_reset = 1'b0;
    sb.delete();
    repeat (400) @(negedge i_clock);
    check("midrst_no_done", done_count - d0, 32'd0);
    check("midrst_no_frame", mon_frames, f0);
    send(8'h3C, acc);
    wait_frames(f0 + 1, 1000, "midrst_resend");
    check("midrst_bits", {21'b0, mon_last_bits}, 32'h678);

    // 6: random bytes with strobe timing random against o_ready.
    tick_div = 1;
    @(negedge i_clock);
    f0 = mon_frames; d0 = done_count;
    n_acc = 0; attempts = 0;
    while (n_acc < 200 && attempts < 20000) begin
      repeat ($urandom_range(0, 40)) @(negedge i_clock);
      send(8'($urandom), acc);
      if (acc) n_acc++;
      attempts++;
    end
    check("rnd_accepted", n_acc, 32'd200);
    wait_frames(f0 + n_acc, 2000, "rnd_frames");
    @(negedge i_clock);
    check("rnd_sb_empty", sb.size(), 32'd0);
    check("rnd_done_count", done_count - d0, n_acc);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
